// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq
// Brief    : Program-counter sequencer (NEXT/JUMP/BRANCH/CALL/RET) with an
//            optional return-address stack enabled by macro PC_SEQ_RAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_seq #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RAS_DEPTH  = 4,
    parameter int unsigned RESET_ADDR = 0,
    parameter int unsigned STEP       = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] target,
    input  logic             cond,
    output logic [WIDTH-1:0] endereco,
    output logic             ras_full,
    output logic             ras_empty,
    output logic             ras_err
);
    localparam int unsigned       c_sp_w       = $clog2(RAS_DEPTH + 1);
    localparam logic [WIDTH-1:0]  c_reset_addr = WIDTH'(RESET_ADDR);
    localparam logic [WIDTH-1:0]  c_step       = WIDTH'(STEP);
    localparam logic [c_sp_w-1:0] c_depth      = c_sp_w'(RAS_DEPTH);

    localparam logic [2:0] c_op_jump   = 3'b001;
    localparam logic [2:0] c_op_branch = 3'b010;
    localparam logic [2:0] c_op_call   = 3'b011;
    localparam logic [2:0] c_op_ret    = 3'b100;

    logic [WIDTH-1:0]  r_pc_q;
    logic [WIDTH-1:0]  w_pc_d;
    logic [WIDTH-1:0]  w_pc_seq;
    logic [WIDTH-1:0]  w_top;
    logic [c_sp_w-1:0] w_sp;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_fault;

    assign w_pc_seq = r_pc_q + c_step;
    assign w_full   = (w_sp == c_depth);
    assign w_empty  = (w_sp == '0);

    always_comb begin
        w_pc_d  = r_pc_q;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        w_fault = 1'b0;
        if (!hold) begin
            w_pc_d = w_pc_seq;
            case (op)
                c_op_jump: w_pc_d = target;
                c_op_branch: begin
                    if (cond) begin
                        w_pc_d = r_pc_q + target;
                    end
                end
                c_op_call: begin
                    w_pc_d = target;
                    if (w_full) begin
                        w_fault = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                c_op_ret: begin
                    // An empty stack degrades RET into a plain sequential step.
                    if (w_empty) begin
                        w_fault = 1'b1;
                    end else begin
                        w_pc_d = w_top;
                        w_pop  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc_q <= c_reset_addr;
        end else begin
            r_pc_q <= w_pc_d;
        end
    end

    assign endereco = r_pc_q;

`ifdef PC_SEQ_RAS_EN
    localparam int unsigned c_idx_w = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0]   r_ras_q [RAS_DEPTH];
    logic [c_sp_w-1:0]  r_sp_q;
    logic [c_sp_w-1:0]  w_sp_d;
    logic [c_sp_w-1:0]  w_sp_m1;
    logic               r_err_q;
    logic               w_err_d;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_rd_idx;

    assign w_sp     = r_sp_q;
    assign w_sp_m1  = r_sp_q - c_sp_w'(1);
    assign w_wr_idx = r_sp_q[c_idx_w-1:0];
    assign w_rd_idx = w_sp_m1[c_idx_w-1:0];
    assign w_top    = r_ras_q[w_rd_idx];

    always_comb begin
        w_sp_d  = r_sp_q;
        w_err_d = r_err_q | w_fault;
        if (w_push) begin
            w_sp_d = r_sp_q + c_sp_w'(1);
        end else if (w_pop) begin
            w_sp_d = w_sp_m1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sp_q  <= '0;
            r_err_q <= 1'b0;
        end else begin
            r_sp_q  <= w_sp_d;
            r_err_q <= w_err_d;
        end
    end

    // Entry contents are left as-is on reset; the pointer alone defines validity.
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_ras_q[w_wr_idx] <= w_pc_seq;
        end
    end

    assign ras_err = r_err_q;
`else
    logic w_unused;

    assign w_sp     = '0;
    assign w_top    = '0;
    assign ras_err  = 1'b0;
    assign w_unused = ^{w_push, w_pop, w_fault};
`endif

    assign ras_full  = w_full;
    assign ras_empty = w_empty;

endmodule
`default_nettype wire

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: address/program-counter width in bits (legal 4..32).
REQ-002 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries (legal 2..16).
REQ-003 SHALL have parameter RESET_ADDR, default 0: value loaded into the counter on reset.
REQ-004 SHALL have parameter STEP, default 1: sequential increment.
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port hold, input, 1: 1 = freeze counter and stack; 0 = execute op.
REQ-008 SHALL have port op, input, 3: operation select (see REQ-012).
REQ-009 SHALL have port target, input, WIDTH: absolute address for JUMP/CALL; signed offset for BRANCH.
REQ-010 SHALL have port cond, input, 1: branch-taken qualifier, used only by BRANCH.
REQ-011 SHALL have ports endereco (output, WIDTH, current counter value, registered), ras_full (output, 1, stack holds RAS_DEPTH entries), ras_empty (output, 1, stack holds 0 entries) and ras_err (output, 1, sticky stack-fault flag).

Function
REQ-012 SHALL decode op as: 000 NEXT, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET; 101-111 behave as NEXT with no error.
REQ-013 SHALL apply this per-edge priority: reset > hold > op.
REQ-014 SHALL, on NEXT, load endereco + STEP modulo 2^WIDTH (all-ones + 1 wraps to 0).
REQ-015 SHALL, on JUMP, load target.
REQ-016 SHALL, on BRANCH with cond=1, load endereco + target (two's complement, modulo 2^WIDTH); with cond=0, behave as NEXT.
REQ-017 SHALL, on CALL with stack not full, push endereco + STEP (wrapped) and load target.
REQ-018 SHALL, on CALL with stack full, load target, leave the stack unchanged and set ras_err.
REQ-019 SHALL, on RET with stack not empty, pop the top entry into the counter (LIFO).
REQ-020 SHALL, on RET with stack empty, behave as NEXT and set ras_err.
REQ-021 SHALL, while hold=1, keep counter, stack pointer, stack contents and ras_err unchanged, regardless of op.
REQ-022 SHALL make endereco reflect the new value in the cycle after the sampling edge (one-cycle latency) and SHALL have no combinational path from inputs to endereco.
REQ-023 SHALL derive ras_full and ras_empty combinationally from the registered stack pointer only.
REQ-024 SHALL hold ras_err at 1 once set, clearing it only on reset.

Reset
REQ-025 SHALL, on reset=1 at a rising edge, set endereco=RESET_ADDR, stack pointer=0 (ras_empty=1, ras_full=0) and ras_err=0, ignoring hold and op.
REQ-026 SHALL discard any operation in progress when reset is asserted mid-sequence; stack entry contents need not be cleared.
REQ-027 SHALL power up with the same values as after reset, for simulation only.

Configuration
REQ-028 SHALL, with macro PC_SEQ_RAS_EN defined, implement the return-address stack per REQ-017..REQ-020.
REQ-029 SHALL, without PC_SEQ_RAS_EN, include no stack storage; CALL behaves as JUMP, RET behaves as NEXT, and ras_empty=1, ras_full=0, ras_err=0 constantly.

Verification (WIDTH=8, RAS_DEPTH=4, STEP=1, RESET_ADDR=0, PC_SEQ_RAS_EN defined)
REQ-030 SHALL cover reset then 3 cycles of NEXT -> endereco 0,1,2,3; JUMP target=0xFF then NEXT -> 0xFF, 0x00.
REQ-031 SHALL cover endereco=0x10, BRANCH target=0xFC cond=1 -> 0x0C; at 0x0C, BRANCH cond=0 -> 0x0D.
REQ-032 SHALL cover from 0x20: CALL 0x40, CALL 0x60, RET, RET -> 0x40, 0x60, 0x41, 0x21, with ras_empty=1 at the end.
REQ-033 SHALL cover 4 CALLs (ras_full=1) then a 5th CALL to 0x80 -> endereco=0x80, ras_err=1, and 4 subsequent RETs return the first four pushed addresses in LIFO order.
REQ-034 SHALL cover RET on an empty stack at 0x05 -> endereco=0x06 and ras_err=1 persisting through subsequent NEXTs until reset.
REQ-035 SHALL cover hold=1 with op=CALL for 3 cycles -> endereco and stack unchanged; reset asserted together with hold=1 -> endereco=0x00, ras_empty=1.
